hazard_pattern_decoder: RTL

- Receive-side counterpart of the Hazard_Lights encoder: it observes the 3-bit light pattern and recovers the wind mode that produced it.
- Flags illegal steps and counts them.
- Sits beside Hazard_Lights in DE1_SoC, tapped off the same `out` bus as the LEDR[2:0] drive.
- Used for on-board self-check and as a scoreboard in benches.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_step_classifier.sv | 32 +++
 rtl/hazard_pattern_decoder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and pattern constants for the hazard-light encoder and decoder.
// Both sides import this so the pattern encodings cannot drift apart.
package hazard_pkg;

    typedef enum logic [1:0] {
        M_CALM = 2'b00,
        M_RTL  = 2'b01,
        M_LTR  = 2'b10,
        M_UNK  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [2:0] P_OUTER = 3'b101;
    localparam logic [2:0] P_MID   = 3'b010;
    localparam logic [2:0] P_RIGHT = 3'b001;
    localparam logic [2:0] P_LEFT  = 3'b100;

    function automatic logic is_legal(input logic [2:0] p);
        return (p == P_OUTER) || (p == P_MID) || (p == P_RIGHT) || (p == P_LEFT);
    endfunction

endpackage

// File: rtl/hazard_step_classifier.sv
// Classifies one (prev -> cur) light transition into the wind mode that produces it.
// Purely combinational; anything that is not a known step (including repeats) is invalid.
module hazard_step_classifier
    import hazard_pkg::*;
(
    input  logic [2:0] prev,
    input  logic [2:0] cur,
    output mode_t      step_class,
    output logic       invalid
);

    always_comb begin
        step_class = M_UNK;
        invalid    = 1'b1;
        case ({prev, cur})
            {P_OUTER, P_MID}, {P_MID, P_OUTER}: begin
                step_class = M_CALM;
                invalid    = 1'b0;
            end
            {P_RIGHT, P_MID}, {P_MID, P_LEFT}, {P_LEFT, P_RIGHT}: begin
                step_class = M_RTL;
                invalid    = 1'b0;
            end
            {P_LEFT, P_MID}, {P_MID, P_RIGHT}, {P_RIGHT, P_LEFT}: begin
                step_class = M_LTR;
                invalid    = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_pattern_decoder.sv
// Recovers the wind mode from the observed hazard-light pattern stream,
// confirms it over CONFIRM consecutive steps and counts illegal steps.
module hazard_pattern_decoder
    import hazard_pkg::*;
#(
    parameter int CONFIRM = 3,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       pattern_in,
    output logic [1:0]       mode,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int             RUN_W  = 4;
    localparam logic [RUN_W-1:0] CONF_R = RUN_W'(CONFIRM);

    state_t           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    mode_t            cand_q, cand_d;
    logic [RUN_W-1:0] run_q, run_d;
    mode_t            mode_q, mode_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    mode_t            step_class;
    logic             step_invalid;
    logic [RUN_W-1:0] run_new;

    hazard_step_classifier u_cls (
        .prev       (prev_q),
        .cur        (pattern_in),
        .step_class (step_class),
        .invalid    (step_invalid)
    );

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        cand_d      = cand_q;
        run_d       = run_q;
        mode_d      = mode_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        run_new     = run_q;

        if (in_valid) begin
            case (state_q)
                S_INIT: begin
                    if (is_legal(pattern_in)) begin
                        prev_d  = pattern_in;
                        state_d = S_TRACK;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
                    end
                end
                S_TRACK, S_LOCKED: begin
                    if (step_invalid) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
                        run_d    = '0;
                        locked_d = 1'b0;
                        if (is_legal(pattern_in)) begin
                            prev_d  = pattern_in;
                            state_d = S_TRACK;
                        end else begin
                            state_d = S_INIT;
                        end
                    end else begin
                        prev_d = pattern_in;
                        // While locked cand tracks mode, so a same-class step just
                        // saturates the run and a different class restarts it at 1.
                        if (step_class == cand_q) begin
                            run_new = (run_q >= CONF_R) ? CONF_R : run_q + 1'b1;
                        end else begin
                            cand_d  = step_class;
                            run_new = 1;
                        end
                        run_d = run_new;
                        if (run_new >= CONF_R) begin
                            state_d  = S_LOCKED;
                            mode_d   = step_class;
                            locked_d = 1'b1;
                        end else begin
                            state_d  = S_TRACK;
                            locked_d = 1'b0;
                        end
                    end
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_INIT;
            prev_q      <= 3'b000;
            cand_q      <= M_CALM;
            run_q       <= '0;
            mode_q      <= M_UNK;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cand_q      <= cand_d;
            run_q       <= run_d;
            mode_q      <= mode_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign mode      = mode_q;
    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule
